// File: rtl/mvu_pkg.sv
// mvu_pkg -- shared definitions for the MVU array and its output drains.
//
// Holds the array-level constants (number of MVUs, default vector geometry)
// and the drain FSM state type, so that every MVU slice and every drain
// agree on the same shapes.
package mvu_pkg;

  // MVU array definitions
  localparam int MVU_COUNT = 4;   // MVUs instantiated by the array top level
  localparam int MVU_N     = 64;  // lanes in one MVU output vector
  localparam int MVU_W     = 32;  // bits per lane
  localparam int MVU_L     = 4;   // lanes per drain output beat

  // Drain FSM state
  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_SEND = 1'b1
  } drain_state_e;

  // Width of a beat index; a single-beat vector still needs one bit.
  function automatic int idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage : mvu_pkg

// File: rtl/mvu_drain.sv
// mvu_drain -- serialises one MVU output vector into L-lane beats.
//
// A capture strobe snapshots the full n*w vector; the snapshot is then sent
// as B = n/L beats over a valid/ready interface, lowest lanes first. A new
// capture arriving together with the final beat's transfer reloads the
// snapshot without a bubble; any other capture while draining is dropped and
// raises a sticky overflow flag.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cap, I           capture strobe and the n*w input vector (lane k at I[k*w +: w])
//   clr_ovf          clears the sticky overflow flag (a same-cycle set wins)
//   O_data, O_valid  current beat (L lanes, lowest lane in low bits) and its valid
//   O_ready          downstream accepts the beat
//   O_idx, O_last    index of the current beat, high on beat B-1
//   busy, ovf        snapshot being drained, capture was dropped (sticky)
module mvu_drain
  import mvu_pkg::*;
#(
  parameter int n = MVU_N,
  parameter int w = MVU_W,
  parameter int L = MVU_L,
  localparam int B  = n / L,
  localparam int IW = idx_width(n / L)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cap,
  input  logic [n*w-1:0]  I,
  input  logic            clr_ovf,
  output logic [L*w-1:0]  O_data,
  output logic            O_valid,
  input  logic            O_ready,
  output logic [IW-1:0]   O_idx,
  output logic            O_last,
  output logic            busy,
  output logic            ovf
);

  localparam int BW = L * w;  // bits per beat

  drain_state_e   state_q, state_d;
  logic [IW-1:0]  beat_q, beat_d;
  logic [n*w-1:0] snap_q, snap_d;
  logic           ovf_q, ovf_d;

  logic xfer;     // a beat is handed downstream this cycle
  logic at_last;  // the current beat is the final one of the vector

  assign xfer    = (state_q == DRAIN_SEND) && O_ready;
  assign at_last = (beat_q == IW'(B - 1));

  // State register
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DRAIN_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers
  // NOTE: the snapshot is a plain register bank, not a RAM, and is reset so
  // O_data reads as zero after reset rather than exposing stale lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      snap_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      snap_q <= snap_d;
      ovf_q  <= ovf_d;
    end
  end

  // Next-state logic
  // NOTE: every signal driven here gets a hold/default value first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    snap_d  = snap_q;
    ovf_d   = ovf_q & ~clr_ovf;

    case (state_q)
      DRAIN_IDLE: begin
        if (cap) begin
          state_d = DRAIN_SEND;
          snap_d  = I;
          beat_d  = '0;
        end
      end
      DRAIN_SEND: begin
        if (xfer && at_last) begin
          // Final beat leaves: either chain straight into a fresh vector or
          // go idle. The index returns to 0 in both cases, never wrapping.
          beat_d = '0;
          if (cap) snap_d  = I;
          else     state_d = DRAIN_IDLE;
        end else begin
          if (xfer) beat_d = beat_q + IW'(1);
          // Capture not coincident with the final transfer: drop it. The set
          // overrides the clear applied above.
          if (cap)  ovf_d  = 1'b1;
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  // Outputs, all derived from registered state so they hold while stalled
  always_comb begin
    busy    = (state_q == DRAIN_SEND);
    O_valid = busy;
    O_idx   = beat_q;
    O_last  = at_last;
    O_data  = snap_q[int'(beat_q) * BW +: BW];
    ovf     = ovf_q;
  end

endmodule : mvu_drain

// File: tb/tb_mvu_drain.sv
// Bench for mvu_drain at n=8, w=8, L=2 (four 16-bit beats per vector).
// A negedge monitor keeps a scoreboard of expected beats, filled when a
// capture is accepted and drained on every transfer; scenario tasks add
// directed checks of their own.
module tb_mvu_drain;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int LN = 2;
  localparam int NB = N / LN;

  typedef struct {
    logic [LN*W-1:0] data;
    logic [1:0]      idx;
    logic            last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cap = 1'b0;
  logic [N*W-1:0]  I = '0;
  logic            clr_ovf = 1'b0;
  logic [LN*W-1:0] O_data;
  logic            O_valid;
  logic            O_ready = 1'b0;
  logic [1:0]      O_idx;
  logic            O_last;
  logic            busy;
  logic            ovf;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t exp_q[$];
  logic  m_ovf = 1'b0;

  mvu_drain #(.n(N), .w(W), .L(LN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cap     (cap),
    .I       (I),
    .clr_ovf (clr_ovf),
    .O_data  (O_data),
    .O_valid (O_valid),
    .O_ready (O_ready),
    .O_idx   (O_idx),
    .O_last  (O_last),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: inputs change at posedge+1, so at negedge both the
  // stimulus and the registered outputs are stable for this cycle.
  always @(negedge clk) begin
    int    sz;
    bit    xf;
    bit    dropped;
    beat_t e;
    if (!rst_n) begin
      exp_q.delete();
      m_ovf = 1'b0;
      n_cmp++;
      if ({O_valid, busy, O_idx, O_last, O_data, ovf} !== '0) begin
        n_bad++;
        $display("FAIL mon_reset: valid=%b busy=%b idx=%0d last=%b data=%h ovf=%b, expected all zero",
                 O_valid, busy, O_idx, O_last, O_data, ovf);
      end
    end else begin
      sz = exp_q.size();
      n_cmp++;
      if (O_valid !== (sz != 0)) begin
        n_bad++;
        $display("FAIL mon_valid: O_valid=%b expected %b", O_valid, sz != 0);
      end
      n_cmp++;
      if (ovf !== m_ovf) begin
        n_bad++;
        $display("FAIL mon_ovf: ovf=%b expected %b", ovf, m_ovf);
      end
      xf = (sz != 0) && O_ready;
      if (xf) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (O_data !== e.data || O_idx !== e.idx || O_last !== e.last) begin
          n_bad++;
          $display("FAIL mon_beat: data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                   O_data, O_idx, O_last, e.data, e.idx, e.last);
        end
      end
      dropped = 1'b0;
      if (cap) begin
        if (sz == 0 || (xf && sz == 1)) begin
          for (int b = 0; b < NB; b++) begin
            e.data = I[b*LN*W +: LN*W];
            e.idx  = 2'(b);
            e.last = (b == NB - 1);
            exp_q.push_back(e);
          end
        end else begin
          dropped = 1'b1;
        end
      end
      m_ovf = dropped ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] make_vec(input logic [7:0] base);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = base + 8'(k);
    return v;
  endfunction

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (O_valid === 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    n_cmp++;
    if (O_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_timeout: O_valid=%b after %0d cycles, expected 0", tag, O_valid, cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({O_valid, busy, O_idx, O_last, O_data, ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid=%b busy=%b idx=%0d last=%b data=%h ovf=%b, expected zeros",
               O_valid, busy, O_idx, O_last, O_data, ovf);
    end
    rst_n = 1'b1;
    O_ready = 1'b1;
    repeat (2) step();
    n_cmp++;
    if (O_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: valid=%b busy=%b expected 0 0", O_valid, busy);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [4] = '{16'h1110, 16'h1312, 16'h1514, 16'h1716};
    O_ready = 1'b1;
    cap = 1'b1;
    I = make_vec(8'h10);
    step();
    cap = 1'b0;
    for (int b = 0; b < NB; b++) begin
      n_cmp++;
      if (O_valid !== 1'b1 || O_data !== exp_d[b] || O_idx !== 2'(b) || O_last !== (b == 3)) begin
        n_bad++;
        $display("FAIL basic_beat%0d: valid=%b data=%h idx=%0d last=%b expected 1 %h %0d %b",
                 b, O_valid, O_data, O_idx, O_last, exp_d[b], b, b == 3);
      end
      step();
    end
    n_cmp++;
    if (O_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_idle: valid=%b busy=%b expected 0 0", O_valid, busy);
    end
  endtask

  task automatic test_stall();
    O_ready = 1'b1;
    cap = 1'b1;
    I = make_vec(8'h10);
    step();
    cap = 1'b0;
    step();
    O_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (O_valid !== 1'b1 || O_data !== 16'h1312 || O_idx !== 2'd1) begin
        n_bad++;
        $display("FAIL stall_hold%0d: valid=%b data=%h idx=%0d expected 1 1312 1",
                 c, O_valid, O_data, O_idx);
      end
      if (c < 3) step();
    end
    O_ready = 1'b1;
    step();
    n_cmp++;
    if (O_data !== 16'h1514 || O_idx !== 2'd2) begin
      n_bad++;
      $display("FAIL stall_resume: data=%h idx=%0d expected 1514 2", O_data, O_idx);
    end
    wait_idle("stall");
  endtask

  task automatic test_back_to_back();
    O_ready = 1'b1;
    cap = 1'b1;
    I = make_vec(8'h10);
    step();
    cap = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (O_idx !== 2'd3 || O_last !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_last: idx=%0d last=%b expected 3 1", O_idx, O_last);
    end
    cap = 1'b1;
    I = make_vec(8'h20);
    step();
    cap = 1'b0;
    n_cmp++;
    if (O_valid !== 1'b1 || O_data !== 16'h2120 || O_idx !== 2'd0 || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_reload: valid=%b data=%h idx=%0d ovf=%b expected 1 2120 0 0",
               O_valid, O_data, O_idx, ovf);
    end
    wait_idle("b2b");
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ovf: ovf=%b expected 0", ovf);
    end
  endtask

  task automatic test_overflow();
    O_ready = 1'b1;
    cap = 1'b1;
    I = make_vec(8'h10);
    step();
    cap = 1'b0;
    step();
    cap = 1'b1;
    I = make_vec(8'h30);
    step();
    cap = 1'b0;
    n_cmp++;
    if (ovf !== 1'b1 || O_data !== 16'h1514 || O_idx !== 2'd2) begin
      n_bad++;
      $display("FAIL ovf_set: ovf=%b data=%h idx=%0d expected 1 1514 2", ovf, O_data, O_idx);
    end
    cap = 1'b1;
    clr_ovf = 1'b1;
    I = make_vec(8'h40);
    step();
    cap = 1'b0;
    clr_ovf = 1'b0;
    n_cmp++;
    if (ovf !== 1'b1 || O_data !== 16'h1716 || O_idx !== 2'd3) begin
      n_bad++;
      $display("FAIL ovf_set_wins: ovf=%b data=%h idx=%0d expected 1 1716 3", ovf, O_data, O_idx);
    end
    wait_idle("ovf");
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear: ovf=%b expected 0", ovf);
    end
  endtask

  task automatic test_reset_mid();
    O_ready = 1'b1;
    cap = 1'b1;
    I = make_vec(8'h10);
    step();
    cap = 1'b0;
    repeat (2) step();
    n_cmp++;
    if (O_idx !== 2'd2 || O_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_pre: idx=%0d valid=%b expected 2 1", O_idx, O_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({O_valid, busy, O_idx, O_last, O_data, ovf} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_async: valid=%b busy=%b idx=%0d last=%b data=%h ovf=%b, expected zeros",
               O_valid, busy, O_idx, O_last, O_data, ovf);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (O_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid_idle%0d: O_valid=%b expected 0", c, O_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      cap     = ($urandom_range(0, 2) == 0);
      I       = {$urandom, $urandom};
      O_ready = $urandom_range(0, 1) != 0;
      clr_ovf = ($urandom_range(0, 7) == 0);
      step();
    end
    cap = 1'b0;
    clr_ovf = 1'b0;
    O_ready = 1'b1;
    wait_idle("random");
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL random_drain: %0d expected beats never emitted, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mvu_drain
